// File: rtl/io_bank.sv
// Memory-mapped IO bank: GPIO out/in, 32-bit compare timer with interrupt, TX byte FIFO.
// Define IO_BANK_TIMER_EN to build the timer; without it the timer words read 0 and irq is 0.
module io_bank #(
    parameter int FIFO_DEPTH       = 4,
    parameter int GPIO_SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  io_addr,
    input  logic        io_en,
    input  logic        io_we,
    input  logic [31:0] io_data_write,
    output logic [31:0] io_data_read,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] W_GPIO_OUT = 6'h00;
    localparam logic [5:0] W_GPIO_IN  = 6'h01;
    localparam logic [5:0] W_TCOUNT   = 6'h02;
    localparam logic [5:0] W_TCMP     = 6'h03;
    localparam logic [5:0] W_TCTRL    = 6'h04;
    localparam logic [5:0] W_TX_DATA  = 6'h05;
    localparam logic [5:0] W_TX_STAT  = 6'h06;

    logic [5:0] word;
    logic       wr, rd;
    logic       unused_addr;

    assign word        = io_addr[7:2];
    assign wr          = io_en & io_we;
    assign rd          = io_en & ~io_we;
    assign unused_addr = ^io_addr[1:0];

    // GPIO
    logic [GPIO_SYNC_STAGES-1:0][31:0] sync_pipe;
    logic [31:0] gpio_sync;

    assign gpio_sync = sync_pipe[GPIO_SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_out  <= '0;
            sync_pipe <= '0;
        end else begin
            if (wr && word == W_GPIO_OUT) gpio_out <= io_data_write;
            sync_pipe[0] <= gpio_in;
            for (int i = 1; i < GPIO_SYNC_STAGES; i++) sync_pipe[i] <= sync_pipe[i-1];
        end
    end

    // TX FIFO: a pop frees a slot in the same cycle, so push-while-full-and-popping is accepted
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          full, empty, push_req, pop, push, drop;

    assign full     = (count == CW'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign tx_valid = ~empty;
    assign tx_data  = mem[rd_ptr];
    assign push_req = wr && word == W_TX_DATA;
    assign pop      = tx_valid & tx_ready;
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= io_data_write[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            overflow <= drop | (overflow & ~(wr && word == W_TX_STAT && io_data_write[7]));
        end
    end

    logic [31:0] tcount_rd, tcmp_rd, tctrl_rd;

`ifdef IO_BANK_TIMER_EN
    logic [31:0] tcount, tcmp;
    logic        t_en, t_irq_en, t_match, irq_q;
    logic        hit, ctrl_wr, match_n, irq_en_n;

    assign hit      = t_en && (tcount == tcmp);
    assign ctrl_wr  = wr && word == W_TCTRL;
    // a match landing in the same cycle as its W1C clear survives
    assign match_n  = hit | (t_match & ~(ctrl_wr & io_data_write[2]));
    assign irq_en_n = ctrl_wr ? io_data_write[1] : t_irq_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount   <= '0;
            tcmp     <= '0;
            t_en     <= 1'b0;
            t_irq_en <= 1'b0;
            t_match  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && word == W_TCOUNT) tcount <= io_data_write;
            else if (hit)               tcount <= '0;
            else if (t_en)              tcount <= tcount + 32'd1;
            if (wr && word == W_TCMP) tcmp <= io_data_write;
            if (ctrl_wr) t_en <= io_data_write[0];
            t_irq_en <= irq_en_n;
            t_match  <= match_n;
            irq_q    <= match_n & irq_en_n;
        end
    end

    assign irq       = irq_q;
    assign tcount_rd = tcount;
    assign tcmp_rd   = tcmp;
    assign tctrl_rd  = {29'd0, t_match, t_irq_en, t_en};
`else
    assign irq       = 1'b0;
    assign tcount_rd = '0;
    assign tcmp_rd   = '0;
    assign tctrl_rd  = '0;
`endif

    always_comb begin
        io_data_read = '0;
        if (rd) begin
            case (word)
                W_GPIO_OUT: io_data_read = gpio_out;
                W_GPIO_IN:  io_data_read = gpio_sync;
                W_TCOUNT:   io_data_read = tcount_rd;
                W_TCMP:     io_data_read = tcmp_rd;
                W_TCTRL:    io_data_read = tctrl_rd;
                W_TX_STAT:  io_data_read = {24'd0, overflow, 5'(count), empty, full};
                default:    io_data_read = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_io_bank.sv
// Randomized scoreboard bench for io_bank: queue/array reference model, decoupled monitor.
module tb_io_bank;
    localparam int DEPTH = 4;
    localparam int NS    = 2;

    logic        clk = 1'b0, reset = 1'b1;
    logic [7:0]  io_addr = '0;
    logic        io_en = 1'b0, io_we = 1'b0, tx_ready = 1'b0;
    logic [31:0] io_data_write = '0, gpio_in = '0;
    logic [31:0] io_data_read, gpio_out;
    logic [7:0]  tx_data;
    logic        tx_valid, irq;

    always #5 clk = ~clk;

    io_bank #(.FIFO_DEPTH(DEPTH), .GPIO_SYNC_STAGES(NS)) dut (
        .clk(clk), .reset(reset), .io_addr(io_addr), .io_en(io_en), .io_we(io_we),
        .io_data_write(io_data_write), .io_data_read(io_data_read), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .irq(irq));

    int nvec = 0, nerr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // scoreboard queues
    logic [31:0] exp_rd[$];
    logic [7:0]  exp_tx[$];
    logic [33:0] exp_st[$];

    // reference model state
    logic [31:0] m_gout, m_tc, m_tcmp;
    logic [31:0] m_gq[$];
    logic [7:0]  m_fq[$];
    bit          m_ovf, m_ten, m_tie, m_match;

    function automatic logic [31:0] m_read(input logic [5:0] w);
        case (w)
            6'd0: return m_gout;
            6'd1: return m_gq[0];
`ifdef IO_BANK_TIMER_EN
            6'd2: return m_tc;
            6'd3: return m_tcmp;
            6'd4: return {29'd0, m_match, m_tie, m_ten};
`endif
            6'd6: return {24'd0, m_ovf, 5'(m_fq.size()), m_fq.size() == 0, m_fq.size() == DEPTH};
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        m_gout = '0; m_tc = '0; m_tcmp = '0;
        m_ovf = 0; m_ten = 0; m_tie = 0; m_match = 0;
        m_fq.delete();
        m_gq.delete();
        for (int i = 0; i < NS; i++) m_gq.push_back('0);
    endtask

    // one clock cycle with the inputs currently driven; entered/left at posedge+1
    task automatic step(input bit use_k = 1'b0, input logic [31:0] k = '0);
        logic [5:0]  w;
        logic [31:0] wd, ntc;
        bit          wr, pop, full, hit, irq_e;
        w  = io_addr[7:2];
        wd = io_data_write;
        wr = io_en && io_we;
        if (io_en && !io_we) exp_rd.push_back(use_k ? k : m_read(w));
        pop = (m_fq.size() != 0) && tx_ready;
        if (pop) exp_tx.push_back(m_fq[0]);
`ifdef IO_BANK_TIMER_EN
        irq_e = m_match && m_tie;
`else
        irq_e = 0;
`endif
        exp_st.push_back({m_gout, irq_e, m_fq.size() != 0});
        if (wr && w == 0) m_gout = wd;
        hit = m_ten && (m_tc == m_tcmp);
        ntc = m_tc;
        if (m_ten) ntc = hit ? 32'd0 : m_tc + 32'd1;
        if (wr && w == 2) ntc = wd;
        if (wr && w == 3) m_tcmp = wd;
        m_match = hit || (m_match && !(wr && w == 4 && wd[2]));
        if (wr && w == 4) begin m_ten = wd[0]; m_tie = wd[1]; end
        m_tc = ntc;
        full = (m_fq.size() == DEPTH);
        if (pop) void'(m_fq.pop_front());
        if (wr && w == 5) begin
            if (!full || pop) m_fq.push_back(wd[7:0]);
            else m_ovf = 1;
        end else if (wr && w == 6 && wd[7]) m_ovf = 0;
        m_gq.push_back(gpio_in);
        void'(m_gq.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input logic [7:0] a, input logic [31:0] d);
        io_en = 1; io_we = 1; io_addr = a | 8'($urandom_range(0, 3)); io_data_write = d;
        step();
    endtask

    task automatic rd_reg(input logic [7:0] a, input bit use_k = 1'b0, input logic [31:0] k = '0);
        io_en = 1; io_we = 0; io_addr = a | 8'($urandom_range(0, 3)); io_data_write = $urandom;
        step(use_k, k);
    endtask

    task automatic idle(input int n);
        io_en = 0; io_we = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    // monitor
    always @(negedge clk) begin
        logic [33:0] st;
        if (!reset) begin
            if (exp_st.size() > 0) begin
                st = exp_st.pop_front();
                chk("gpio_out", gpio_out, st[33:2]);
                chk("irq", {31'd0, irq}, {31'd0, st[1]});
                chk("tx_valid", {31'd0, tx_valid}, {31'd0, st[0]});
                if (!(io_en && !io_we)) chk("rd_idle", io_data_read, 32'd0);
            end
            if (io_en && !io_we) begin
                if (exp_rd.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL rd_unexpected: got %h want none", io_data_read);
                end else chk("rd", io_data_read, exp_rd.pop_front());
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    nvec++; nerr++;
                    $display("FAIL tx_unexpected: got %h want none", tx_data);
                end else chk("tx_data", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
            end
        end
    end

    initial begin
        logic [5:0]  w;
        logic [31:0] d;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpio_out", gpio_out, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset = 0;
        rd_reg(8'h18, 1, 32'h02);

        // GPIO out and input lag
        wr_reg(8'h00, 32'hDEADBEEF);
        rd_reg(8'h00, 1, 32'hDEADBEEF);
        gpio_in = 32'h0000A5A5;
        rd_reg(8'h04, 1, 32'h0);
        rd_reg(8'h04, 1, 32'h0);
        rd_reg(8'h04, 1, 32'h0000A5A5);

`ifdef IO_BANK_TIMER_EN
        wr_reg(8'h0C, 32'd3);
        wr_reg(8'h10, 32'h3);
        rd_reg(8'h08, 1, 32'd0);
        rd_reg(8'h08, 1, 32'd1);
        rd_reg(8'h08, 1, 32'd2);
        rd_reg(8'h08, 1, 32'd3);
        rd_reg(8'h08, 1, 32'd0);
        wr_reg(8'h10, 32'h7);
        rd_reg(8'h10, 1, 32'h3);
        wr_reg(8'h10, 32'h7);
        rd_reg(8'h10, 1, 32'h7);
        wr_reg(8'h10, 32'h4);
`else
        wr_reg(8'h08, 32'd5);
        wr_reg(8'h0C, 32'd3);
        wr_reg(8'h10, 32'h7);
        rd_reg(8'h08, 1, 32'd0);
        rd_reg(8'h0C, 1, 32'd0);
        rd_reg(8'h10, 1, 32'd0);
`endif

        // FIFO fill, overflow, drain
        tx_ready = 0;
        for (int i = 0; i < 5; i++) wr_reg(8'h14, 32'h11 + i);
        rd_reg(8'h18, 1, 32'h91);
        tx_ready = 1;
        idle(4);
        rd_reg(8'h18, 1, 32'h82);
        wr_reg(8'h18, 32'h80);
        rd_reg(8'h18, 1, 32'h02);

        // push while full with a simultaneous pop
        tx_ready = 0;
        for (int i = 0; i < 4; i++) wr_reg(8'h14, 32'h31 + i);
        tx_ready = 1;
        wr_reg(8'h14, 32'h22);
        tx_ready = 0;
        rd_reg(8'h18, 1, 32'h11);
        tx_ready = 1;
        idle(4);
        tx_ready = 0;

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) gpio_in = $urandom;
            tx_ready = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 9))
                0, 1, 2: idle(1);
                3, 4, 5: begin
                    w = ($urandom_range(0, 7) == 0) ? 6'h3F : 6'($urandom_range(0, 7));
                    rd_reg({w, 2'b00});
                end
                default: begin
                    w = 6'($urandom_range(0, 7));
                    case (w)
                        6'd2, 6'd3: d = $urandom_range(0, 20);
                        6'd4:       d = $urandom_range(0, 7);
                        6'd5:       d = $urandom_range(0, 255);
                        default:    d = $urandom;
                    endcase
                    wr_reg({w, 2'b00}, d);
                end
            endcase
        end

        // asynchronous reset mid-operation
        tx_ready = 0;
        wr_reg(8'h18, 32'h80);
        idle(DEPTH);
        tx_ready = 1;
        idle(DEPTH);
        tx_ready = 0;
        for (int i = 0; i < 3; i++) wr_reg(8'h14, 32'h40 + i);
`ifdef IO_BANK_TIMER_EN
        wr_reg(8'h0C, 32'd1000);
        wr_reg(8'h08, 32'd0);
        wr_reg(8'h10, 32'h3);
`endif
        wr_reg(8'h00, 32'h12345678);
        idle(1);
        #2 reset = 1;
        #1;
        chk("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_mid_irq", {31'd0, irq}, 32'd0);
        chk("rst_mid_gpio_out", gpio_out, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        m_reset();
        gpio_in = '0;
        rd_reg(8'h18, 1, 32'h02);
        rd_reg(8'h08, 1, 32'd0);
        rd_reg(8'h08, 1, 32'd0);
        rd_reg(8'h10, 1, 32'd0);
        idle(2);

        chk("rd_q_left", exp_rd.size(), 32'd0);
        chk("tx_q_left", exp_tx.size(), 32'd0);
        chk("st_q_left", exp_st.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/io_bank.md
IO_BANK -- requirements
Module: io_bank

Interface
REQ-001 The block SHALL expose parameter FIFO_DEPTH, default 4, TX FIFO entries (power of two, 2..16).
REQ-002 The block SHALL expose parameter GPIO_SYNC_STAGES, default 2, synchroniser flops on gpio_in (2..3).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-004 clk  input  1  rising-edge clock shared with the MMU.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 io_addr  input  8  registered byte address from the MMU; bits [7:2] select a word and bits [1:0] are ignored.
REQ-007 io_en  input  1  access strobe, valid for one cycle.
REQ-008 io_we  input  1  write qualifier for io_en.
REQ-009 io_data_write  input  32  write data, already lane-shifted by the MMU.
REQ-010 io_data_read  output  32  combinational read data.
REQ-011 gpio_in  input  32  asynchronous external inputs.
REQ-012 gpio_out  output  32  GPIO output register.
REQ-013 tx_data  output  8  FIFO head byte.
REQ-014 tx_valid  output  1  FIFO non-empty.
REQ-015 tx_ready  input  1  consumer accepts the head byte.
REQ-016 irq  output  1  timer interrupt, level.

Function
REQ-017 Register map:
- 0x00 GPIO_OUT, RW.
- 0x04 GPIO_IN, RO: synchronised gpio_in.
- 0x08 TIMER_COUNT, RW.
- 0x0C TIMER_CMP, RW.
- 0x10 TIMER_CTRL: bit0 enable, bit1 irq_en, bit2 match (sticky, W1C).
- 0x14 TX_DATA, WO: writes push bits [7:0]; reads return 0.
- 0x18 TX_STATUS: bit0 full, bit1 empty, bits[6:2] count, bit7 overflow (sticky, W1C).
- All other words read 0 and ignore writes.
REQ-018 A write SHALL occur at the rising edge where io_en && io_we; every write is a full 32-bit write, with no byte enables.
REQ-019 Read data:
- io_data_read SHALL equal the addressed register in the same cycle when io_en && !io_we, and 0 otherwise.
- Reads SHALL have no side effects.
REQ-020 When enable=1, TIMER_COUNT SHALL increment by 1 each cycle.
REQ-021 When TIMER_COUNT == TIMER_CMP with enable=1, the next value SHALL be 0 and match SHALL be set.
REQ-022 A software write to TIMER_COUNT SHALL take priority over the increment and the wrap.
REQ-023 If a match set and a W1C clear of match occur in the same cycle, the set SHALL win.
REQ-024 irq SHALL equal match && irq_en, driven from flops with no combinational path from inputs.
REQ-025 FIFO push and pop:
- A TX_DATA write SHALL push when the FIFO is not full.
- A pop SHALL occur when tx_valid && tx_ready.
- tx_data SHALL be the head entry, held stable while tx_valid && !tx_ready.
REQ-026 Push while full with no pop SHALL be dropped and SHALL set overflow.
REQ-027 Push while full with a simultaneous pop SHALL be accepted, and count SHALL remain FIFO_DEPTH.
REQ-028 Push while empty SHALL assert tx_valid on the next cycle; there is no same-cycle bypass.
REQ-029 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-030 GPIO_IN SHALL lag gpio_in by exactly GPIO_SYNC_STAGES cycles.

Reset
REQ-031 While reset=1, the following SHALL hold at 0 regardless of clk: gpio_out, TIMER_COUNT, TIMER_CMP, TIMER_CTRL, FIFO pointers and count, overflow, the synchroniser flops, irq and tx_valid.
REQ-032 FIFO storage SHALL NOT be reset, and tx_data SHALL be don't-care while tx_valid=0.
REQ-033 Reset asserted mid-operation SHALL discard queued bytes, and tx_valid SHALL fall asynchronously.

Configuration
REQ-034 Macro IO_BANK_TIMER_EN SHALL control the timer.
REQ-035 With IO_BANK_TIMER_EN defined, the timer SHALL be built and behave as in REQ-020 to REQ-024.
REQ-036 Without IO_BANK_TIMER_EN, the timer SHALL be absent:
- 0x08, 0x0C and 0x10 SHALL read 0 and ignore writes.
- irq SHALL be tied to 0.
- No timer flops SHALL be synthesised.

Verification
REQ-037 Write 0xDEADBEEF to 0x00, then read 0x00 -> gpio_out=0xDEADBEEF on the next cycle; the read returns 0xDEADBEEF in the access cycle.
REQ-038 Set gpio_in=0x0000A5A5 -> a GPIO_IN read returns the old value for 2 cycles and 0x0000A5A5 from cycle 2 onward.
REQ-039 (IO_BANK_TIMER_EN) Set CMP=3, then CTRL=0x3 -> count sequence 0,1,2,3,0; match=1 and irq=1 from the wrap cycle; writing CTRL=0x7 clears match unless a match coincides.
REQ-040 With tx_ready=0, push 0x11..0x15 (5 writes) -> count=4, full=1, overflow=1, tx_data=0x11.
REQ-041 Then hold tx_ready=1 -> tx_data sequence 0x11,0x12,0x13,0x14, then tx_valid=0 and empty=1.
REQ-042 With the FIFO full, push 0x22 in the same cycle as a pop -> count stays 4, no overflow, and 0x22 emerges last.
REQ-043 Assert reset with the FIFO holding 3 bytes and the timer running -> all outputs 0 immediately; after release count=0 and the timer is stopped.
